fifo_reader: RTL and testbench
==============================

FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 Parameter DSIZE, default 8, data word width in bits.
REQ-002 Parameter ASIZE, default 4, FIFO address width; max burst length 2**ASIZE words.
REQ-003 rclk  input  1  single clock; all logic on its rising edge.
REQ-004 rrst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  one-cycle request to begin a burst; ignored while busy=1.
REQ-006 len  input  ASIZE+1  burst length in words; sampled when start is accepted.
REQ-007 fifo_rdata  input  DSIZE  FIFO head word, show-ahead: valid in the same cycle whenever fifo_rempty=0.
REQ-008 fifo_rempty  input  1  FIFO empty flag.
REQ-009 fifo_rinc  output  1  FIFO pop strobe; one word is removed per cycle with fifo_rinc=1.
REQ-010 out_data  output  DSIZE  delivered word.
REQ-011 out_valid  output  1  out_data is valid.
REQ-012 out_ready  input  1  sink accepts; transfer occurs when out_valid and out_ready are both 1.
REQ-013 busy  output  1  burst in progress (state READ or DONE).
REQ-014 done  output  1  one-cycle pulse at the end of a burst.
REQ-015 count  output  ASIZE+1  words delivered in the current or last burst.
REQ-016 xor_sum  output  DSIZE  bitwise XOR of all words delivered in the current or last burst.

Function
REQ-017 The state machine SHALL have the states IDLE, READ and DONE.
REQ-018 IDLE: start=1 with len!=0 SHALL latch remaining=len, clear count and xor_sum, and enter READ on the next cycle.
REQ-019 IDLE: start=1 with len=0 SHALL clear count and xor_sum, enter DONE, and perform no FIFO pop.
REQ-020 fifo_rinc SHALL be combinational and equal (state==READ) && !fifo_rempty && remaining!=0 && buf_cnt<2.
REQ-021 On each pop, fifo_rdata SHALL be written into a 2-entry in-order output buffer, and remaining SHALL decrement by 1.
REQ-022 out_valid SHALL equal buf_cnt!=0; out_data SHALL be the oldest buffered word and SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 A push and a pop in the same cycle SHALL leave buf_cnt unchanged; this gives one word per cycle sustained throughput.
REQ-024 Each transfer SHALL increment count by 1 and XOR out_data into xor_sum.
REQ-025 READ SHALL go to DONE in the cycle after remaining==0, buf_cnt==0.
REQ-026 DONE SHALL last exactly one cycle with done=1, then go to IDLE.
REQ-027 Latency: a word present at the FIFO head in READ with buf_cnt=0 SHALL appear on out_data with out_valid=1 on the next cycle.
REQ-028 fifo_rempty=1 mid-burst SHALL stall popping without loss of the burst; popping resumes when fifo_rempty=0.
REQ-029 Counter arithmetic SHALL be unsigned modulo its width; len is never exceeded.

Reset
REQ-030 rrst_n=0 at a clock edge SHALL force state=IDLE, buf_cnt=0, remaining=0, count=0, xor_sum=0.
REQ-031 Outputs during and after reset SHALL be: fifo_rinc=0, out_valid=0, busy=0, done=0, out_data=0.
REQ-032 Reset in the middle of a burst SHALL discard buffered words with no further pops.

Structure
REQ-033 The state encodings (IDLE=2'd0, READ=2'd1, DONE=2'd2) SHALL reside in the shared package fifo_pkg, together with the default DSIZE and ASIZE.
REQ-034 The 2-entry output buffer SHALL be the sub-module fifo_skid2 (ports: push, push_data, pop, head, cnt).

Verification
REQ-035 Reset, then start with len=4, FIFO holding A1,B2,C3,D4, out_ready=1 -> 4 consecutive transfers A1..D4, count=4, xor_sum=0x04, done pulses once.
REQ-036 len=4 with out_ready=0 for 5 cycles -> exactly 2 pops, out_data=A1 held stable, no words lost after out_ready=1.
REQ-037 FIFO empty after 2 of 3 words, third word arrives 6 cycles later -> burst completes with count=3, busy=1 throughout the gap.
REQ-038 start with len=0 -> done on the next cycle, zero pops, count=0.
REQ-039 rrst_n=0 for 1 cycle mid-burst -> next cycle state IDLE, all outputs 0, FIFO contents untouched; start while busy -> ignored.
REQ-040 Random streams of 16 words with random out_ready -> out_data order equals FIFO write order, and xor_sum matches the reference model.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg
//   Shared definitions for the FIFO burst reader: default data/address
//   widths and the reader state encoding.
package fifo_pkg;

  localparam int FIFO_DSIZE = 8;  // default data word width
  localparam int FIFO_ASIZE = 4;  // default FIFO address width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } fifo_state_e;

endpackage

// File: rtl/fifo_reader_if.sv
// fifo_reader_if
//   Bundles the reader's control, FIFO read side and output stream.
//   Ports (slave = reader view):
//     start, len               burst request and length
//     fifo_rdata, fifo_rempty  show-ahead FIFO head and empty flag
//     fifo_rinc                FIFO pop strobe
//     out_data, out_valid      delivered word stream
//     out_ready                sink acceptance
//     busy, done               burst status
//     count, xor_sum           statistics of the current/last burst
interface fifo_reader_if
  import fifo_pkg::*;
#(
  parameter int DSIZE = FIFO_DSIZE,
  parameter int ASIZE = FIFO_ASIZE
);

  logic             start;
  logic [ASIZE:0]   len;
  logic [DSIZE-1:0] fifo_rdata;
  logic             fifo_rempty;
  logic             fifo_rinc;
  logic [DSIZE-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             done;
  logic [ASIZE:0]   count;
  logic [DSIZE-1:0] xor_sum;

  modport slave (
    input  start, len, fifo_rdata, fifo_rempty, out_ready,
    output fifo_rinc, out_data, out_valid, busy, done, count, xor_sum
  );

  modport master (
    output start, len, fifo_rdata, fifo_rempty, out_ready,
    input  fifo_rinc, out_data, out_valid, busy, done, count, xor_sum
  );

endinterface

// File: rtl/fifo_skid2.sv
// fifo_skid2
//   Two-entry in-order buffer between the FIFO pop and the output stream.
//   Ports:
//     clk, rst_n  clock and synchronous active-low reset
//     push        write push_data (ignored when full unless popping too)
//     push_data   word to store
//     pop         remove the oldest word (ignored when empty)
//     head        oldest stored word
//     cnt         number of stored words (0..2)
module fifo_skid2 #(
  parameter int DSIZE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [DSIZE-1:0] push_data,
  input  logic             pop,
  output logic [DSIZE-1:0] head,
  output logic [1:0]       cnt
);

  logic [DSIZE-1:0] ent0;
  logic [DSIZE-1:0] ent1;
  logic [1:0]       cnt_q;
  logic             pop_ok;
  logic             push_ok;

  assign pop_ok  = pop && (cnt_q != 2'd0);
  assign push_ok = push && ((cnt_q != 2'd2) || pop_ok);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ent0  <= '0;
      ent1  <= '0;
      cnt_q <= 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (cnt_q == 2'd0) ent0 <= push_data;
          else               ent1 <= push_data;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          ent0  <= ent1;
          cnt_q <= cnt_q - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop keeps the occupancy; the new word lands
          // behind whatever remains after the pop.
          if (cnt_q == 2'd1) begin
            ent0 <= push_data;
          end else begin
            ent0 <= ent1;
            ent1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = ent0;
  assign cnt  = cnt_q;

endmodule

// File: rtl/fifo_reader.sv
// fifo_reader
//   Reads a burst of len words from a show-ahead FIFO and streams them out
//   with a valid/ready handshake, keeping a word count and running XOR.
//   Ports:
//     rclk    clock
//     rrst_n  synchronous active-low reset
//     bus     fifo_reader_if slave: start/len request, FIFO read side,
//             out_data/out_valid/out_ready stream, busy/done/count/xor_sum
//
//   state | meaning
//   IDLE  | waiting for start
//   READ  | popping FIFO and delivering words
//   DONE  | one-cycle done pulse, then back to IDLE
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int DSIZE = FIFO_DSIZE,
  parameter int ASIZE = FIFO_ASIZE
) (
  input  logic      rclk,
  input  logic      rrst_n,
  fifo_reader_if.slave bus
);

  fifo_state_e      state;
  logic [ASIZE:0]   remaining;
  logic [ASIZE:0]   count_q;
  logic [DSIZE-1:0] xor_q;
  logic [1:0]       buf_cnt;
  logic [DSIZE-1:0] head;
  logic             push;
  logic             pop;

  // Reset gates the pop strobe so a mid-burst reset never removes a word.
  assign push = rrst_n && (state == READ) && !bus.fifo_rempty &&
                (remaining != '0) && (buf_cnt < 2'd2);
  assign pop  = (buf_cnt != 2'd0) && bus.out_ready;

  fifo_skid2 #(.DSIZE(DSIZE)) u_skid (
    .clk       (rclk),
    .rst_n     (rrst_n),
    .push      (push),
    .push_data (bus.fifo_rdata),
    .pop       (pop),
    .head      (head),
    .cnt       (buf_cnt)
  );

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      state     <= IDLE;
      remaining <= '0;
      count_q   <= '0;
      xor_q     <= '0;
    end else begin
      if (pop) begin
        count_q <= count_q + 1'b1;
        xor_q   <= xor_q ^ head;
      end
      case (state)
        IDLE: begin
          if (bus.start) begin
            count_q <= '0;
            xor_q   <= '0;
            if (bus.len != '0) begin
              remaining <= bus.len;
              state     <= READ;
            end else begin
              state <= DONE;
            end
          end
        end
        READ: begin
          if (push) remaining <= remaining - 1'b1;
          if ((remaining == '0) && (buf_cnt == 2'd0)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.fifo_rinc = push;
  assign bus.out_valid = (buf_cnt != 2'd0);
  assign bus.out_data  = head;
  assign bus.busy      = (state == READ) || (state == DONE);
  assign bus.done      = (state == DONE);
  assign bus.count     = count_q;
  assign bus.xor_sum   = xor_q;

endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader
//   Directed bench for fifo_reader: a table of bursts plus hand-written
//   stall, gap, zero-length, reset and random-stream sequences. The FIFO is
//   a small show-ahead model driven from bench-owned memory.
module tb_fifo_reader;

  logic rclk;
  logic rrst_n;

  fifo_reader_if #(.DSIZE(8), .ASIZE(4)) bus ();

  fifo_reader #(.DSIZE(8), .ASIZE(4)) dut (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .bus    (bus)
  );

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  // FIFO model
  logic [7:0] mem [64];
  int wr_ptr = 0;
  int rd_ptr = 0;
  logic fifo_flush = 1'b0;

  assign bus.fifo_rempty = (rd_ptr == wr_ptr);
  assign bus.fifo_rdata  = mem[rd_ptr % 64];

  always @(posedge rclk) begin
    if (fifo_flush)         rd_ptr <= wr_ptr;
    else if (bus.fifo_rinc) rd_ptr <= rd_ptr + 1;
  end

  // Output monitor
  logic [7:0] got [64];
  int ngot = 0;
  int npops = 0;
  int ndone = 0;
  logic mon_clr = 1'b0;

  always @(posedge rclk) begin
    if (mon_clr) begin
      ngot  <= 0;
      npops <= 0;
      ndone <= 0;
    end else begin
      if (bus.out_valid && bus.out_ready && ngot < 64) begin
        got[ngot] <= bus.out_data;
        ngot      <= ngot + 1;
      end
      if (bus.fifo_rinc) npops <= npops + 1;
      if (bus.done)      ndone <= ndone + 1;
    end
  end

  int nvec = 0;
  int nmis = 0;
  logic [7:0] expw [64];
  int nld = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic flush();
    @(negedge rclk);
    fifo_flush = 1'b1;
    mon_clr    = 1'b1;
    @(negedge rclk);
    fifo_flush = 1'b0;
    mon_clr    = 1'b0;
    nld        = 0;
  endtask

  task automatic load_word(input logic [7:0] d);
    mem[wr_ptr % 64] = d;
    expw[nld] = d;
    nld++;
    wr_ptr++;
  endtask

  task automatic wait_done(input string nm, input logic [15:0] m);
    int cyc;
    cyc = 1;
    while (ndone == 0 && cyc < 300) begin
      bus.out_ready = m[cyc % 16];
      @(negedge rclk);
      cyc++;
    end
    chk({nm, "_finished"}, (ndone != 0), 1);
  endtask

  task automatic run_burst(input string nm, input int l, input logic [15:0] m);
    @(negedge rclk);
    bus.start     = 1'b1;
    bus.len       = 5'(l);
    bus.out_ready = m[0];
    @(negedge rclk);
    bus.start = 1'b0;
    wait_done(nm, m);
    @(negedge rclk);
  endtask

  task automatic chk_order(input string nm, input int l);
    logic ok;
    ok = 1'b1;
    for (int k = 0; k < l; k++)
      if (got[k] !== expw[k]) ok = 1'b0;
    chk({nm, "_order"}, ok, 1);
  endtask

  typedef struct {
    int         blen;
    logic [7:0] base;
    logic [15:0] mask;
    int         extra;
    int         exp_cnt;
    logic [7:0] exp_xor;
  } vec_t;

  vec_t vt [8];

  initial begin
    logic [7:0] w;
    logic [7:0] model_xor;
    logic [15:0] m;
    logic ok;

    // words are base + j*0x11; expected XOR worked out by hand
    vt[0] = '{4,  8'hA1, 16'hFFFF, 0, 4,  8'h04};
    vt[1] = '{1,  8'h5A, 16'hFFFF, 0, 1,  8'h5A};
    vt[2] = '{3,  8'h10, 16'hFFFF, 0, 3,  8'h03};
    vt[3] = '{2,  8'hF0, 16'hFFFF, 2, 2,  8'hF1};
    vt[4] = '{0,  8'h00, 16'hFFFF, 1, 0,  8'h00};
    vt[5] = '{4,  8'h01, 16'hAAAA, 0, 4,  8'h04};
    vt[6] = '{16, 8'h00, 16'h6DB7, 0, 16, 8'h00};
    vt[7] = '{5,  8'h80, 16'h0F0F, 0, 5,  8'hC4};

    bus.start     = 1'b0;
    bus.len       = '0;
    bus.out_ready = 1'b0;
    rrst_n        = 1'b0;
    mon_clr       = 1'b1;
    @(negedge rclk);
    @(negedge rclk);
    chk("rst_rinc",  bus.fifo_rinc, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_busy",  bus.busy, 0);
    chk("rst_done",  bus.done, 0);
    chk("rst_data",  bus.out_data, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_xor",   bus.xor_sum, 0);
    rrst_n  = 1'b1;
    mon_clr = 1'b0;

    for (int i = 0; i < 8; i++) begin
      string nm;
      nm = $sformatf("v%0d", i);
      flush();
      for (int j = 0; j < vt[i].blen + vt[i].extra; j++) begin
        w = vt[i].base + 8'(j * 17);
        load_word(w);
      end
      run_burst(nm, vt[i].blen, vt[i].mask);
      chk({nm, "_count"}, bus.count, vt[i].exp_cnt);
      chk({nm, "_xor"}, bus.xor_sum, vt[i].exp_xor);
      chk({nm, "_ngot"}, ngot, vt[i].exp_cnt);
      chk({nm, "_pops"}, npops, vt[i].blen);
      chk({nm, "_ndone"}, ndone, 1);
      chk({nm, "_left"}, wr_ptr - rd_ptr, vt[i].extra);
      chk({nm, "_idle"}, bus.busy, 0);
      chk_order(nm, vt[i].blen);
    end

    // Output stall: only two pops, head held, start while busy ignored
    flush();
    for (int j = 0; j < 4; j++) load_word(8'hA1 + 8'(j * 17));
    @(negedge rclk);
    bus.start     = 1'b1;
    bus.len       = 5'd4;
    bus.out_ready = 1'b0;
    @(negedge rclk);
    bus.start = 1'b0;
    chk("lat_first_valid", bus.out_valid, 0);
    chk("lat_first_rinc", bus.fifo_rinc, 1);
    @(negedge rclk);
    chk("lat_valid", bus.out_valid, 1);
    chk("lat_data", bus.out_data, 8'hA1);
    ok = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        bus.start = 1'b1;
        bus.len   = 5'd1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge rclk);
      if (!bus.out_valid || bus.out_data !== 8'hA1) ok = 1'b0;
    end
    bus.start = 1'b0;
    chk("stall_hold", ok, 1);
    chk("stall_pops", npops, 2);
    wait_done("stall", 16'hFFFF);
    @(negedge rclk);
    chk("stall_count", bus.count, 4);
    chk("stall_xor", bus.xor_sum, 8'h04);
    chk("stall_pops_end", npops, 4);
    chk_order("stall", 4);

    // FIFO runs dry after two words; third arrives six cycles later
    flush();
    load_word(8'h10);
    load_word(8'h21);
    @(negedge rclk);
    bus.start     = 1'b1;
    bus.len       = 5'd3;
    bus.out_ready = 1'b1;
    @(negedge rclk);
    bus.start = 1'b0;
    ok = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge rclk);
      if (!bus.busy) ok = 1'b0;
    end
    chk("gap_busy", ok, 1);
    chk("gap_pops", npops, 2);
    load_word(8'h32);
    wait_done("gap", 16'hFFFF);
    @(negedge rclk);
    chk("gap_count", bus.count, 3);
    chk("gap_xor", bus.xor_sum, 8'h03);
    chk_order("gap", 3);

    // Zero-length burst: done on the very next cycle
    flush();
    load_word(8'h77);
    @(negedge rclk);
    bus.start = 1'b1;
    bus.len   = 5'd0;
    @(negedge rclk);
    bus.start = 1'b0;
    chk("len0_done", bus.done, 1);
    chk("len0_busy", bus.busy, 1);
    chk("len0_count", bus.count, 0);
    @(negedge rclk);
    chk("len0_done_end", bus.done, 0);
    chk("len0_pops", npops, 0);

    // Reset mid-burst with two words buffered
    flush();
    for (int j = 0; j < 4; j++) load_word(8'hA1 + 8'(j * 17));
    @(negedge rclk);
    bus.start     = 1'b1;
    bus.len       = 5'd4;
    bus.out_ready = 1'b0;
    @(negedge rclk);
    bus.start = 1'b0;
    @(negedge rclk);
    @(negedge rclk);
    rrst_n = 1'b0;
    @(negedge rclk);
    rrst_n = 1'b1;
    chk("mrst_rinc",  bus.fifo_rinc, 0);
    chk("mrst_valid", bus.out_valid, 0);
    chk("mrst_busy",  bus.busy, 0);
    chk("mrst_data",  bus.out_data, 0);
    chk("mrst_count", bus.count, 0);
    @(negedge rclk);
    @(negedge rclk);
    chk("mrst_pops", npops, 2);
    chk("mrst_left", wr_ptr - rd_ptr, 2);
    chk("mrst_idle", bus.busy, 0);

    // Random 16-word streams with random backpressure
    for (int r = 0; r < 3; r++) begin
      string nm;
      nm = $sformatf("rnd%0d", r);
      flush();
      model_xor = 8'h00;
      for (int j = 0; j < 16; j++) begin
        w = 8'($urandom_range(0, 255));
        model_xor = model_xor ^ w;
        load_word(w);
      end
      m = 16'($urandom) | 16'h0001;
      run_burst(nm, 16, m);
      chk({nm, "_count"}, bus.count, 16);
      chk({nm, "_xor"}, bus.xor_sum, model_xor);
      chk_order(nm, 16);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
